// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: FSM states and the per-stage control bundle.
package pipeline_hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_BUBBLE = 2'd1,
        ST_FREEZE = 2'd2
    } state_e;

    typedef struct packed {
        logic pc_write;
        logic ifid_write;
        logic ifid_flush;
        logic idex_flush;
        logic idex_write;
        logic exmem_write;
        logic memwb_bubble;
    } ctrl_t;

    localparam ctrl_t CTRL_RUN    = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b0, idex_flush: 1'b0,
                                      idex_write: 1'b1, exmem_write: 1'b1, memwb_bubble: 1'b0};
    localparam ctrl_t CTRL_RESET  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b1, idex_flush: 1'b1,
                                      idex_write: 1'b0, exmem_write: 1'b0, memwb_bubble: 1'b1};
    localparam ctrl_t CTRL_FREEZE = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b0,
                                      idex_write: 1'b0, exmem_write: 1'b0, memwb_bubble: 1'b1};
    localparam ctrl_t CTRL_BRANCH = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b1,
                                      idex_write: 1'b1, exmem_write: 1'b1, memwb_bubble: 1'b0};
    localparam ctrl_t CTRL_STALL  = '{pc_write: 1'b0, ifid_write: 1'b0, ifid_flush: 1'b0, idex_flush: 1'b1,
                                      idex_write: 1'b1, exmem_write: 1'b1, memwb_bubble: 1'b0};
    localparam ctrl_t CTRL_JUMP   = '{pc_write: 1'b1, ifid_write: 1'b1, ifid_flush: 1'b1, idex_flush: 1'b0,
                                      idex_write: 1'b1, exmem_write: 1'b1, memwb_bubble: 1'b0};

endpackage

// File: rtl/pipeline_hazard_ctrl_sat_counter.sv
// Saturating up-counter: holds at all-ones instead of wrapping.
module pipeline_hazard_ctrl_sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline stage write/flush/bubble control from stall, branch, jump and memory-busy events,
// with a one-bubble-per-load-use FSM, a freeze watchdog and saturating event counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W      = 32,
    parameter int unsigned FREEZE_MAX = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall_req,
    input  logic             ex_branch_taken,
    input  logic             id_jump,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_flush,
    output logic             idex_write,
    output logic             exmem_write,
    output logic             memwb_bubble,
    output logic             freeze_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] freeze_cnt
);

    localparam int unsigned RUN_W = $clog2(FREEZE_MAX + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FREEZE_MAX);

    state_e           state_q, state_d;
    state_e           ret_q, ret_d;
    state_e           eff_state;
    logic [RUN_W-1:0] run_q, run_d;
    logic             timeout_q, timeout_d;
    logic             stall_inc, flush_inc, freeze_inc;
    ctrl_t            ctrl;

    // While frozen, the pipeline behaves as the state it froze in once memory releases.
    assign eff_state = (state_q == ST_FREEZE) ? ret_q : state_q;

    always_comb begin
        ctrl       = CTRL_RUN;
        state_d    = state_q;
        ret_d      = ret_q;
        run_d      = '0;
        timeout_d  = timeout_q;
        stall_inc  = 1'b0;
        flush_inc  = 1'b0;
        freeze_inc = 1'b0;
        if (reset) begin
            ctrl = CTRL_RESET;
        end else if (mem_busy) begin
            ctrl       = CTRL_FREEZE;
            state_d    = ST_FREEZE;
            ret_d      = eff_state;
            freeze_inc = 1'b1;
            run_d      = (run_q == RUN_MAX) ? run_q : run_q + RUN_W'(1);
            if (run_d == RUN_MAX) begin
                timeout_d = 1'b1;
            end
        end else begin
            state_d = ST_RUN;
            if (ex_branch_taken) begin
                ctrl      = CTRL_BRANCH;
                flush_inc = 1'b1;
            end else if (stall_req && (eff_state == ST_RUN)) begin
                ctrl      = CTRL_STALL;
                state_d   = ST_BUBBLE;
                stall_inc = 1'b1;
            end else if (id_jump) begin
                ctrl      = CTRL_JUMP;
                flush_inc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_RUN;
            ret_q     <= ST_RUN;
            run_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_q     <= ret_d;
            run_q     <= run_d;
            timeout_q <= timeout_d;
        end
    end

    assign pc_write       = ctrl.pc_write;
    assign ifid_write     = ctrl.ifid_write;
    assign ifid_flush     = ctrl.ifid_flush;
    assign idex_flush     = ctrl.idex_flush;
    assign idex_write     = ctrl.idex_write;
    assign exmem_write    = ctrl.exmem_write;
    assign memwb_bubble   = ctrl.memwb_bubble;
    assign freeze_timeout = timeout_q;

    pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk(clk), .reset(reset), .inc(stall_inc), .count(stall_cnt)
    );

    pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk(clk), .reset(reset), .inc(flush_inc), .count(flush_cnt)
    );

    pipeline_hazard_ctrl_sat_counter #(.W(CNT_W)) u_freeze_cnt (
        .clk(clk), .reset(reset), .inc(freeze_inc), .count(freeze_cnt)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: directed hazard scenarios followed by random traffic.
module tb_pipeline_hazard_ctrl;

    localparam int unsigned CNT_W      = 3;
    localparam int unsigned FREEZE_MAX = 4;
    localparam int          CMAX       = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic stall_req = 1'b0, ex_branch_taken = 1'b0, id_jump = 1'b0, mem_busy = 1'b0;
    logic pc_write, ifid_write, ifid_flush, idex_flush, idex_write, exmem_write, memwb_bubble;
    logic freeze_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt, freeze_cnt;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .FREEZE_MAX(FREEZE_MAX)) dut (
        .clk(clk), .reset(reset), .stall_req(stall_req), .ex_branch_taken(ex_branch_taken),
        .id_jump(id_jump), .mem_busy(mem_busy), .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .idex_flush(idex_flush), .idex_write(idex_write),
        .exmem_write(exmem_write), .memwb_bubble(memwb_bubble), .freeze_timeout(freeze_timeout),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .freeze_cnt(freeze_cnt)
    );

    typedef struct {
        logic [6:0]       ctrl;
        logic             to;
        logic [3*CNT_W-1:0] cnt;
        bit               chk;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   running  = 0;

    // Reference model: abstract pipeline status rather than FSM encoding.
    bit known = 0;
    bit mask_next = 0;
    int busy_run = 0;
    bit m_to = 0;
    int m_stall = 0, m_flush = 0, m_freeze = 0;

    function automatic int sat(input int v);
        return (v >= CMAX) ? CMAX : v + 1;
    endfunction

    // ctrl order: pc_write ifid_write ifid_flush idex_flush idex_write exmem_write memwb_bubble
    task automatic step(input logic r, input logic st, input logic br, input logic jp, input logic mb);
        exp_t e;
        @(negedge clk);
        reset = r; stall_req = st; ex_branch_taken = br; id_jump = jp; mem_busy = mb;
        e.chk = known;
        e.to  = m_to;
        e.cnt = {CNT_W'(m_stall), CNT_W'(m_flush), CNT_W'(m_freeze)};
        if (r) begin
            e.ctrl = 7'b0011001;
            known = 1; mask_next = 0; busy_run = 0; m_to = 0;
            m_stall = 0; m_flush = 0; m_freeze = 0;
        end else if (mb) begin
            e.ctrl = 7'b0000001;
            m_freeze = sat(m_freeze);
            if (busy_run < FREEZE_MAX) busy_run++;
            if (busy_run == FREEZE_MAX) m_to = 1;
        end else begin
            busy_run = 0;
            if (br) begin
                e.ctrl = 7'b1111110; m_flush = sat(m_flush); mask_next = 0;
            end else if (st && !mask_next) begin
                e.ctrl = 7'b0001110; m_stall = sat(m_stall); mask_next = 1;
            end else if (jp) begin
                e.ctrl = 7'b1110110; m_flush = sat(m_flush); mask_next = 0;
            end else begin
                e.ctrl = 7'b1100110; mask_next = 0;
            end
        end
        q.push_back(e);
        running = 1;
    endtask

    // Monitor: outputs are valid every cycle once inputs settle; sample mid-low-phase.
    initial begin
        exp_t e;
        logic [6:0] act;
        forever begin
            @(negedge clk);
            #3;
            if (running) begin
                n_checks++;
                if (q.size() == 0) begin
                    n_fail++;
                    $display("FAIL scoreboard_empty: no expected entry at time %0t", $time);
                end else begin
                    e = q.pop_front();
                    act = {pc_write, ifid_write, ifid_flush, idex_flush, idex_write, exmem_write, memwb_bubble};
                    if (act !== e.ctrl) begin
                        n_fail++;
                        $display("FAIL ctrl @%0t: got %b expected %b", $time, act, e.ctrl);
                    end
                    if (e.chk) begin
                        n_checks += 2;
                        if (freeze_timeout !== e.to) begin
                            n_fail++;
                            $display("FAIL freeze_timeout @%0t: got %b expected %b", $time, freeze_timeout, e.to);
                        end
                        if ({stall_cnt, flush_cnt, freeze_cnt} !== e.cnt) begin
                            n_fail++;
                            $display("FAIL counters @%0t: got stall=%0d flush=%0d freeze=%0d expected %0d/%0d/%0d",
                                     $time, stall_cnt, flush_cnt, freeze_cnt,
                                     e.cnt[3*CNT_W-1:2*CNT_W], e.cnt[2*CNT_W-1:CNT_W], e.cnt[CNT_W-1:0]);
                        end
                    end
                end
            end
        end
    end

    initial begin
        // reset for two cycles
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // stall_req held three cycles: stall, masked, stall
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // branch beats stall and jump in the same cycle
        step(1, 0, 0, 0, 0);
        step(0, 1, 1, 1, 0);
        step(0, 0, 0, 0, 0);
        // freeze during a bubble cycle, then release without a second bubble
        step(1, 0, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        repeat (5) step(0, 1, 0, 0, 1);
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // watchdog: six busy cycles, sticky until reset
        step(1, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 1);
        repeat (3) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        // counter saturation: nine branch flushes
        repeat (9) step(0, 0, 1, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        // random traffic
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 49) == 0),
                 ($urandom_range(0, 2) == 0),
                 ($urandom_range(0, 6) == 0),
                 ($urandom_range(0, 4) == 0),
                 ($urandom_range(0, 5) == 0));
        end
        #4;
        running = 0;
        @(negedge clk);
        n_checks++;
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
